// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit with HI/LO registers
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // Counter holds values up to the longer of the two latencies minus one.
  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   a_q, b_q;
  logic [3:0]    op_q;
  logic [31:0]   hi_q, lo_q;

  logic          start_ok;
  logic [63:0]   prod_s, prod_u;
  logic signed [31:0] sa, sb, quot_s, rem_s;
  logic [31:0]   quot_u, rem_u;
  logic          div_ovf;

  assign start_ok = start && (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);

  // Products come from the sign- or zero-extended latched operands.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  assign sa      = a_q;
  assign sb      = b_q;
  assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

  // Division results; the zero-divisor case is never committed, and the
  // most-negative / -1 overflow is pinned to a defined answer.
  always_comb begin
    quot_s = '0;
    rem_s  = '0;
    quot_u = '0;
    rem_u  = '0;
    if (b_q != 32'd0) begin
      quot_u = a_q / b_q;
      rem_u  = a_q % b_q;
      if (div_ovf) begin
        quot_s = 32'sh8000_0000;
        rem_s  = '0;
      end else begin
        quot_s = sa / sb;
        rem_s  = sa % sb;
      end
    end
  end

  // Control FSM, operand latches, countdown and HI/LO update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (state_q == S_IDLE) begin
      if (start_ok) begin
        state_q <= S_BUSY;
        a_q     <= A;
        b_q     <= B;
        op_q    <= MDUOp;
        cnt_q   <= (MDUOp <= OP_MULTU) ? MULT_LOAD : DIV_LOAD;
      end else if (MDUOp == OP_MTHI) begin
        hi_q <= A;
      end else if (MDUOp == OP_MTLO) begin
        lo_q <= A;
      end
    end else begin
      if (cnt_q == '0) begin
        state_q <= S_IDLE;
        case (op_q)
          OP_MULT:  begin hi_q <= prod_s[63:32]; lo_q <= prod_s[31:0]; end
          OP_MULTU: begin hi_q <= prod_u[63:32]; lo_q <= prod_u[31:0]; end
          OP_DIV:   if (b_q != 32'd0) begin hi_q <= rem_s; lo_q <= quot_s; end
          OP_DIVU:  if (b_q != 32'd0) begin hi_q <= rem_u; lo_q <= quot_u; end
          default:  ;
        endcase
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign busy = (state_q == S_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Move-from reads the live registers; stalling on busy is the caller's job.
  always_comb begin
    MDUOut = 32'd0;
    if (MDUOp == OP_MFHI)      MDUOut = hi_q;
    else if (MDUOp == OP_MFLO) MDUOut = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for mdu
module tb_mdu;

  logic        clk;
  logic        rst;
  logic [31:0] A, B;
  logic [3:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI, LO, MDUOut;

  int total = 0;
  int bad   = 0;
  int n;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .MDUOp(MDUOp), .start(start),
    .busy(busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one request across a single rising edge; returns at the next falling edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic st);
    A = a; B = b; MDUOp = op; start = st;
    @(posedge clk);
    #1;
    start = 1'b0; MDUOp = 4'd0;
    @(negedge clk);
  endtask

  // Count falling edges at which busy is still high, with a bound.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    if (cnt >= 100) chk("busy_timeout", 32'(cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b0; A = '0; B = '0; MDUOp = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_out", MDUOut, 32'd0);
    rst = 1'b1;

    // mult taken on the very first edge after reset release
    issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_idle(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFE);

    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_idle(n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    issue(4'd4, 32'd7, 32'd2, 1'b1);
    wait_idle(n);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle(n);
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'd0);

    issue(4'd4, 32'hFFFF_FFFF, 32'h10, 1'b1);
    wait_idle(n);
    chk("divu_big_lo", LO, 32'h0FFF_FFFF);
    chk("divu_big_hi", HI, 32'h0000_000F);

    // divide by zero leaves HI/LO untouched
    issue(4'd7, 32'h11, 32'd0, 1'b0);
    issue(4'd8, 32'h22, 32'd0, 1'b0);
    chk("mthi_11", HI, 32'h11);
    chk("mtlo_22", LO, 32'h22);
    issue(4'd3, 32'd100, 32'd0, 1'b1);
    wait_idle(n);
    chk("div0_cycles", 32'(n), 32'd10);
    chk("div0_hi", HI, 32'h11);
    chk("div0_lo", LO, 32'h22);

    // requests while busy are ignored; operands stay latched
    issue(4'd1, 32'd3, 32'd4, 1'b1);
    issue(4'd3, 32'd100, 32'd7, 1'b1);
    issue(4'd7, 32'h55, 32'd9, 1'b0);
    MDUOp = 4'd5; #1;
    chk("mfhi_busy", MDUOut, 32'h11);
    MDUOp = 4'd0;
    wait_idle(n);
    chk("ign_cycles", 32'(n + 2), 32'd5);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd12);
    @(negedge clk);
    chk("ign_no_restart", {31'd0, busy}, 32'd0);

    // move-to / move-from and MDUOut decode
    issue(4'd7, 32'hAB, 32'd0, 1'b0);
    MDUOp = 4'd5; #1; chk("mfhi", MDUOut, 32'hAB);
    MDUOp = 4'd6; #1; chk("mflo", MDUOut, 32'd12);
    MDUOp = 4'd0; #1; chk("none_out", MDUOut, 32'd0);
    MDUOp = 4'd9; #1; chk("op9_out", MDUOut, 32'd0);
    @(negedge clk);

    // start with a non-arithmetic code starts nothing
    issue(4'd5, 32'd1, 32'd1, 1'b1);
    chk("start_mfhi_busy", {31'd0, busy}, 32'd0);
    issue(4'd12, 32'd1, 32'd1, 1'b1);
    chk("start_op12_busy", {31'd0, busy}, 32'd0);
    chk("start_op12_hi", HI, 32'hAB);

    // reset mid-division aborts without commit
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    issue(4'd1, 32'd3, 32'd4, 1'b1);
    wait_idle(n);
    chk("post_rst_cycles", 32'(n), 32'd5);
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
